// File: rtl/sysc_brk_trap_unit_pkg.sv
// Shared definitions for the SYSCALL/BREAK trap unit:
// op encodings, exception codes and FSM state encoding.
package sysc_brk_trap_unit_pkg;

   localparam logic [1:0] SB_BREAK      = 2'b01;
   localparam logic [1:0] SB_SYSCALL    = 2'b10;
   localparam logic [1:0] INVALID_OP_2B = 2'b11;

   localparam logic [5:0] ECODE_SYS = 6'h0B;
   localparam logic [5:0] ECODE_BRK = 6'h0C;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_COMMIT   = 2'd1,
      ST_FLUSH    = 2'd2,
      ST_REDIRECT = 2'd3
   } sb_state_e;

endpackage

// File: rtl/sysc_brk_trap_unit.sv
// SYSCALL/BREAK trap sequencer: commits trap CSRs,
// flushes the pipeline, then redirects fetch to EENTRY.
module sysc_brk_trap_unit
   import sysc_brk_trap_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [31:0] req_pc,
   input  logic [1:0]  csr_crmd_plv,
   input  logic        csr_crmd_ie,
   input  logic [31:0] csr_eentry,
   output logic        csr_we,
   output logic [31:0] csr_era,
   output logic [5:0]  csr_ecode,
   output logic [8:0]  csr_esubcode,
   output logic [1:0]  csr_pplv,
   output logic        csr_pie,
   output logic        flush,
   input  logic        flush_ack,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   input  logic        redirect_ready,
   output logic        busy
);

   sb_state_e   state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] eentry_q, eentry_d;
   logic [1:0]  plv_q, plv_d;
   logic        ie_q, ie_d;
   logic        brk_q, brk_d;

   logic is_sys;
   logic is_brk;
   logic accept;

   // Classify the incoming op; anything else is dropped.
   always_comb begin
      is_sys = 1'b0;
      is_brk = 1'b0;
      unique case (1'b1)
         (req_op == SB_SYSCALL): is_sys = 1'b1;
         (req_op == SB_BREAK):   is_brk = 1'b1;
         default: ;
      endcase
   end

   assign accept = req_valid & req_ready;

   // Next state, trap context capture and all outputs.
   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      eentry_d       = eentry_q;
      plv_d          = plv_q;
      ie_d           = ie_q;
      brk_d          = brk_q;
      req_ready      = 1'b0;
      busy           = 1'b1;
      csr_we         = 1'b0;
      csr_era        = '0;
      csr_ecode      = '0;
      csr_esubcode   = '0;
      csr_pplv       = '0;
      csr_pie        = 1'b0;
      flush          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      unique case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (accept && (is_sys || is_brk)) begin
               pc_d     = req_pc;
               eentry_d = csr_eentry;
               plv_d    = csr_crmd_plv;
               ie_d     = csr_crmd_ie;
               brk_d    = is_brk;
               state_d  = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            csr_we    = 1'b1;
            csr_era   = pc_q;
            csr_ecode = brk_q ? ECODE_BRK : ECODE_SYS;
            csr_pplv  = plv_q;
            csr_pie   = ie_q;
            state_d   = ST_FLUSH;
         end
         ST_FLUSH: begin
            flush = 1'b1;
            if (flush_ack) state_d = ST_REDIRECT;
         end
         ST_REDIRECT: begin
            redirect_valid = 1'b1;
            redirect_pc    = eentry_q;
            if (redirect_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and latched trap context registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         pc_q     <= '0;
         eentry_q <= '0;
         plv_q    <= '0;
         ie_q     <= 1'b0;
         brk_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         eentry_q <= eentry_d;
         plv_q    <= plv_d;
         ie_q     <= ie_d;
         brk_q    <= brk_d;
      end
   end

endmodule

// File: tb/tb_sysc_brk_trap_unit.sv
// Self-checking bench for sysc_brk_trap_unit: directed
// scenarios plus randomized traffic against a trap model.
module tb_sysc_brk_trap_unit;
   import sysc_brk_trap_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_op = 2'b00;
   logic [31:0] req_pc = '0;
   logic [1:0]  csr_crmd_plv = '0;
   logic        csr_crmd_ie = 1'b0;
   logic [31:0] csr_eentry = '0;
   logic        csr_we;
   logic [31:0] csr_era;
   logic [5:0]  csr_ecode;
   logic [8:0]  csr_esubcode;
   logic [1:0]  csr_pplv;
   logic        csr_pie;
   logic        flush;
   logic        flush_ack = 1'b0;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        redirect_ready = 1'b0;
   logic        busy;

   int total = 0;
   int bad   = 0;
   int we_cnt = 0;

   sysc_brk_trap_unit dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_pc(req_pc),
      .csr_crmd_plv(csr_crmd_plv), .csr_crmd_ie(csr_crmd_ie),
      .csr_eentry(csr_eentry),
      .csr_we(csr_we), .csr_era(csr_era),
      .csr_ecode(csr_ecode), .csr_esubcode(csr_esubcode),
      .csr_pplv(csr_pplv), .csr_pie(csr_pie),
      .flush(flush), .flush_ack(flush_ack),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .redirect_ready(redirect_ready),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Trap model: m_step counts cycles since the accepted request
   // (0 = no trap in progress). Steps 1..3 follow the fixed
   // commit / flush / redirect progression; flush and redirect
   // stretch while their handshakes are outstanding.
   int          m_step = 0;
   logic [31:0] m_pc, m_ee;
   logic [1:0]  m_plv;
   logic        m_ie, m_brk;

   always @(posedge rst) m_step = 0;

   always @(posedge clk) begin
      if (rst) m_step = 0;
      else if (m_step == 0) begin
         if (req_valid && (req_op == SB_SYSCALL || req_op == SB_BREAK)) begin
            m_pc  = req_pc;
            m_ee  = csr_eentry;
            m_plv = csr_crmd_plv;
            m_ie  = csr_crmd_ie;
            m_brk = (req_op == SB_BREAK);
            m_step = 1;
         end
      end else if (m_step == 1) m_step = 2;
      else if (m_step == 2) begin
         if (flush_ack) m_step = 3;
      end else if (redirect_ready) m_step = 0;
   end

   // Per-cycle comparison of every DUT output with the model.
   always @(negedge clk) begin
      logic cw;
      cw = (m_step == 1);
      if (csr_we === 1'b1) we_cnt++;
      check("req_ready", 32'(req_ready), 32'(m_step == 0));
      check("busy", 32'(busy), 32'(m_step != 0));
      check("csr_we", 32'(csr_we), 32'(cw));
      check("csr_era", csr_era, cw ? m_pc : 32'd0);
      check("csr_ecode", 32'(csr_ecode),
            cw ? (m_brk ? 32'd12 : 32'd11) : 32'd0);
      check("csr_esubcode", 32'(csr_esubcode), 32'd0);
      check("csr_pplv", 32'(csr_pplv), cw ? 32'(m_plv) : 32'd0);
      check("csr_pie", 32'(csr_pie), cw ? 32'(m_ie) : 32'd0);
      check("flush", 32'(flush), 32'(m_step == 2));
      check("redirect_valid", 32'(redirect_valid), 32'(m_step == 3));
      check("redirect_pc", redirect_pc, (m_step == 3) ? m_ee : 32'd0);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      req_valid = 1'b0;
      req_op    = 2'b00;
   endtask

   initial begin
      int w0;
      cyc();
      @(negedge clk);
      check("rst req_ready", 32'(req_ready), 32'd1);
      check("rst busy", 32'(busy), 32'd0);
      cyc();
      rst = 1'b0;

      // SYSCALL with handshakes tied high
      flush_ack = 1'b1;
      redirect_ready = 1'b1;
      req_valid = 1'b1;
      req_op = SB_SYSCALL;
      req_pc = 32'h1C000100;
      csr_crmd_plv = 2'd3;
      csr_crmd_ie = 1'b1;
      csr_eentry = 32'h1C008000;
      cyc();
      idle_in();
      @(negedge clk);
      check("sys we", 32'(csr_we), 32'd1);
      check("sys era", csr_era, 32'h1C000100);
      check("sys ecode", 32'(csr_ecode), 32'h0B);
      check("sys pplv", 32'(csr_pplv), 32'd3);
      check("sys pie", 32'(csr_pie), 32'd1);
      cyc();
      @(negedge clk);
      check("sys flush", 32'(flush), 32'd1);
      cyc();
      @(negedge clk);
      check("sys rv", 32'(redirect_valid), 32'd1);
      check("sys rpc", redirect_pc, 32'h1C008000);
      cyc();
      @(negedge clk);
      check("sys idle", 32'(req_ready), 32'd1);

      // BREAK at PLV0 / IE0
      cyc();
      req_valid = 1'b1;
      req_op = SB_BREAK;
      req_pc = 32'h1C000200;
      csr_crmd_plv = 2'd0;
      csr_crmd_ie = 1'b0;
      cyc();
      idle_in();
      @(negedge clk);
      check("brk ecode", 32'(csr_ecode), 32'h0C);
      check("brk pplv", 32'(csr_pplv), 32'd0);
      check("brk pie", 32'(csr_pie), 32'd0);
      check("brk esub", 32'(csr_esubcode), 32'd0);
      check("brk era", csr_era, 32'h1C000200);
      repeat (4) cyc();

      // INVALID op is consumed silently
      req_valid = 1'b1;
      req_op = INVALID_OP_2B;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("inv ready", 32'(req_ready), 32'd1);
         check("inv busy", 32'(busy | csr_we | flush | redirect_valid), 32'd0);
         cyc();
      end
      idle_in();

      // Delayed handshakes, EENTRY changes mid-trap
      flush_ack = 1'b0;
      redirect_ready = 1'b0;
      req_valid = 1'b1;
      req_op = SB_SYSCALL;
      req_pc = 32'h1C000300;
      csr_eentry = 32'h1C00A000;
      cyc();
      idle_in();
      csr_eentry = 32'hDEAD0000;
      cyc();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("dly flush wait", 32'(flush), 32'd1);
         cyc();
      end
      flush_ack = 1'b1;
      @(negedge clk);
      check("dly flush ack", 32'(flush), 32'd1);
      cyc();
      flush_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("dly flush off", 32'(flush), 32'd0);
         check("dly rpc", redirect_pc, 32'h1C00A000);
         csr_eentry = 32'hBEEF0000 + i;
         cyc();
      end
      redirect_ready = 1'b1;
      @(negedge clk);
      check("dly rv", 32'(redirect_valid), 32'd1);
      cyc();
      @(negedge clk);
      check("dly idle", 32'(req_ready), 32'd1);

      // Reset during FLUSH
      flush_ack = 1'b0;
      req_valid = 1'b1;
      req_op = SB_SYSCALL;
      cyc();
      idle_in();
      cyc();
      @(negedge clk);
      check("rstf in flush", 32'(flush), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("rstf async flush", 32'(flush), 32'd0);
      check("rstf async ready", 32'(req_ready), 32'd1);
      check("rstf async busy", 32'(busy), 32'd0);
      cyc();
      rst = 1'b0;
      flush_ack = 1'b1;
      w0 = we_cnt;
      repeat (5) begin
         @(negedge clk);
         check("rstf no rv", 32'(redirect_valid), 32'd0);
         cyc();
      end
      check("rstf no we", 32'(we_cnt - w0), 32'd0);
      req_valid = 1'b1;
      req_op = SB_SYSCALL;
      req_pc = 32'h1C000400;
      cyc();
      idle_in();
      @(negedge clk);
      check("rstf next we", 32'(csr_we), 32'd1);
      repeat (4) cyc();

      // Back-to-back SYSCALLs with req_valid held six cycles
      w0 = we_cnt;
      req_valid = 1'b1;
      req_op = SB_SYSCALL;
      repeat (6) cyc();
      idle_in();
      repeat (6) cyc();
      check("b2b we pulses", 32'(we_cnt - w0), 32'd2);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         req_valid = ($urandom_range(0, 2) != 0);
         req_op = 2'($urandom_range(0, 3));
         req_pc = $urandom;
         csr_crmd_plv = 2'($urandom_range(0, 3));
         csr_crmd_ie = 1'($urandom_range(0, 1));
         csr_eentry = $urandom;
         flush_ack = ($urandom_range(0, 2) == 0);
         redirect_ready = ($urandom_range(0, 2) == 0);
         rst = ($urandom_range(0, 79) == 0);
         cyc();
      end
      rst = 1'b0;
      idle_in();
      repeat (2) cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sysc_brk_trap_unit.md
SYSC_BRK_TRAP_UNIT -- requirements
Module: sysc_brk_trap_unit

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 req_valid  input  1  decode stage presents a classified SYSCALL/BREAK op.
REQ-004 req_ready  output  1  unit can accept a request; high only in IDLE.
REQ-005 req_op  input  2  op type encoded with shared SB_BREAK / SB_SYSCALL / INVALID_OP_2B.
REQ-006 req_pc  input  32  PC of the trapping instruction.
REQ-007 csr_crmd_plv  input  2  current privilege level (CRMD.PLV).
REQ-008 csr_crmd_ie  input  1  current interrupt enable (CRMD.IE).
REQ-009 csr_eentry  input  32  exception entry address (EENTRY).
REQ-010 csr_we  output  1  one-cycle CSR trap-commit strobe.
REQ-011 csr_era  output  32  value for ERA.
REQ-012 csr_ecode  output  6  value for ESTAT.Ecode.
REQ-013 csr_esubcode  output  9  value for ESTAT.EsubCode.
REQ-014 csr_pplv  output  2  value for PRMD.PPLV.
REQ-015 csr_pie  output  1  value for PRMD.PIE.
REQ-016 flush  output  1  pipeline flush request, held until acknowledged.
REQ-017 flush_ack  input  1  pipeline flush complete.
REQ-018 redirect_valid  output  1  fetch redirect request.
REQ-019 redirect_pc  output  32  redirect target.
REQ-020 redirect_ready  input  1  fetch accepts redirect.
REQ-021 busy  output  1  high in any state other than IDLE.

Function
REQ-022 FSM states SHALL be IDLE, COMMIT, FLUSH, REDIRECT.
REQ-023 Accept = req_valid & req_ready; an accept with SB_SYSCALL or SB_BREAK SHALL latch req_pc, op, csr_crmd_plv, csr_crmd_ie, csr_eentry and go IDLE->COMMIT.
REQ-024 An accept with INVALID_OP_2B (or any other code) SHALL be consumed with no state change and no outputs asserted.
REQ-025 COMMIT SHALL last exactly one cycle with csr_we=1, csr_era=latched pc, csr_ecode=6'h0B (SYSCALL) or 6'h0C (BREAK), csr_esubcode=0, csr_pplv/csr_pie=latched plv/ie; then go to FLUSH.
REQ-026 CSR outputs SHALL be zero whenever csr_we=0.
REQ-027 FLUSH SHALL assert flush for at least one cycle; flush_ack sampled high while in FLUSH SHALL move to REDIRECT next cycle; flush_ack outside FLUSH SHALL be ignored.
REQ-028 REDIRECT SHALL hold redirect_valid=1 and redirect_pc=latched eentry stable until redirect_ready=1; that cycle completes the handshake and returns to IDLE.
REQ-029 Latency: accept in cycle T -> csr_we in T+1 -> flush from T+2 -> redirect_valid no earlier than T+3; req_ready returns no earlier than T+4.
REQ-030 No request SHALL be accepted while busy; req_valid held during busy SHALL be accepted on first IDLE cycle.
REQ-031 redirect_pc SHALL use the EENTRY value latched at accept, not the live input.

Reset
REQ-032 rst SHALL immediately force IDLE and drive req_ready=1, busy=0, csr_we=0, flush=0, redirect_valid=0, all data outputs 0.
REQ-033 rst asserted in any non-IDLE state SHALL abandon the trap; no csr_we or redirect SHALL follow after release.

Structure
REQ-034 ECODE_SYS (6'h0B), ECODE_BRK (6'h0C) and the FSM state encoding SHALL live in the shared defs header beside SB_BREAK/SB_SYSCALL/INVALID_OP_2B.
REQ-035 Single flat module; no sub-module; estimated 150-220 lines.

Verification
REQ-036 SYSCALL, pc=0x1C000100, plv=3, ie=1, eentry=0x1C008000, flush_ack and redirect_ready tied high -> csr_we at T+1 with era=0x1C000100, ecode=0x0B, pplv=3, pie=1; redirect_pc=0x1C008000 at T+3; IDLE at T+4.
REQ-037 BREAK, pc=0x1C000200, plv=0, ie=0 -> ecode=0x0C, pplv=0, pie=0, esubcode=0.
REQ-038 INVALID_OP_2B with req_valid=1 -> req_ready stays 1, busy/csr_we/flush/redirect_valid stay 0.
REQ-039 flush_ack delayed 5 cycles, redirect_ready delayed 3 cycles -> flush high exactly through ack cycle; redirect_pc stable while waiting; eentry changed mid-trap does not affect redirect_pc.
REQ-040 rst pulsed during FLUSH -> all outputs 0 asynchronously; no later redirect_valid; next SYSCALL processed normally.
REQ-041 Back-to-back SYSCALL requests with req_valid held -> second accepted only after first redirect handshake; two csr_we pulses total.
